// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I control FSM sequencing the shared datapath and driving ALUcontrol
//   Parameters: STATE_W (width of state_o, >= 4), JALR_EN (1: jalr executes, 0: jalr is an unknown opcode)
//   Macro CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky ILLEGAL state instead of acting as NOPs
//   Inputs : clk, reset (sync, active-high), op[6:0], funct3[2:0], funct7b5, Zero (ALU result == 0)
//   Outputs: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0],
//            ImmSrc[2:0], ALUcontrol[3:0], illegal, state_o[STATE_W-1:0]
module multicycle_ctrl #(
  parameter int STATE_W = 4,
  parameter bit JALR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ImmSrc,
  output logic [3:0]         ALUcontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    LUI      = 4'd11,
    JALR     = 4'd12,
    ILLEGAL  = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  // Destination of an unrecognised opcode out of DECODE
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t BAD = ILLEGAL;
`else
  localparam state_t BAD = FETCH;
`endif

  state_t     state_q, state_d;
  logic       pc_w, adr, mem_w, ir_w, reg_w;
  logic [1:0] res, src_a, src_b;
  logic [2:0] imm;
  logic [3:0] alu, alu_ri, alu_br;
  logic       taken;

  always_comb begin
    case (funct3)
      3'b000:  alu_ri = (state_q == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ri = ALU_SLL;
      3'b010:  alu_ri = ALU_SLT;
      3'b011:  alu_ri = ALU_SLTU;
      3'b100:  alu_ri = ALU_XOR;
      3'b101:  alu_ri = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ri = ALU_OR;
      default: alu_ri = ALU_AND;
    endcase
  end

  // beq/bne compare by sub, blt/bge by slt, bltu/bgeu by sltu; funct3 010/011 are not branches
  assign alu_br = funct3[2:1] == 2'b00 ? ALU_SUB :
                  funct3[2:1] == 2'b10 ? ALU_SLT :
                  funct3[2:1] == 2'b11 ? ALU_SLTU : ALU_ADD;

  // funct3[0] inverts the sense; blt-family tests a set-less-than result, so it is inverted once more by funct3[2]
  assign taken = funct3[2:1] != 2'b01 && (Zero ^ funct3[2] ^ funct3[0]);

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    adr     = 1'b0;
    mem_w   = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    res     = 2'b00;
    src_a   = 2'b00;
    src_b   = 2'b00;
    imm     = 3'b000;
    alu     = ALU_ADD;
    case (state_q)
      FETCH: begin
        ir_w    = 1'b1;
        pc_w    = 1'b1;
        src_b   = 2'b10;
        res     = 2'b10;
        state_d = DECODE;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        imm   = op == OP_BR ? 3'b010 : op == OP_JAL ? 3'b011 : 3'b000;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BR:             state_d = BRANCH;
          OP_LUI:            state_d = LUI;
          OP_JALR:           state_d = JALR_EN ? JALR : BAD;
          default:           state_d = BAD;
        endcase
      end
      MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        imm     = op[5] ? 3'b001 : 3'b000;
        state_d = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr     = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        res     = 2'b01;
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        adr     = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECR: begin
        src_a   = 2'b10;
        alu     = alu_ri;
        state_d = ALUWB;
      end
      EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu     = alu_ri;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        src_a   = 2'b01;
        src_b   = 2'b10;
        pc_w    = 1'b1;
        state_d = ALUWB;
      end
      JALR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        res     = 2'b10;
        pc_w    = 1'b1;
        state_d = JAL;
      end
      BRANCH: begin
        src_a   = 2'b10;
        alu     = alu_br;
        pc_w    = taken;
        state_d = FETCH;
      end
      LUI: begin
        src_a   = 2'b11;
        src_b   = 2'b01;
        imm     = 3'b100;
        state_d = ALUWB;
      end
      ILLEGAL: state_d = ILLEGAL;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) state_q <= reset ? FETCH : state_d;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) illegal_q <= reset ? 1'b0 : (illegal_q | state_d == ILLEGAL);
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Write strobes are suppressed during reset so an aborted instruction cannot commit
  assign PCWrite    = pc_w & ~reset;
  assign IRWrite    = ir_w & ~reset;
  assign RegWrite   = reg_w & ~reset;
  assign MemWrite   = mem_w & ~reset;
  assign AdrSrc     = adr;
  assign ResultSrc  = res;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ImmSrc     = imm;
  assign ALUcontrol = alu;
  assign state_o    = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111, BR = 7'b1100011, LU = 7'b0110111, JR = 7'b1100111;

  logic       clk, reset, funct7b5, Zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUcontrol, state_o;
  int         vectors = 0, miscompares = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUcontrol(ALUcontrol), .illegal(illegal), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       br, il;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int pcw, input int adr, input int memw, input int irw,
                              input int regw, input int res, input int a, input int b, input int imm,
                              input int alu, input int br = 0, input int il = 0);
    mk.st = 4'(s); mk.pcw = 1'(pcw); mk.adr = 1'(adr); mk.memw = 1'(memw); mk.irw = 1'(irw);
    mk.regw = 1'(regw); mk.res = 2'(res); mk.a = 2'(a); mk.b = 2'(b); mk.imm = 3'(imm);
    mk.alu = 4'(alu); mk.br = 1'(br); mk.il = 1'(il);
  endfunction

  function automatic int alu_of(input logic [2:0] f3, input logic f7, input bit rtype);
    int tab[8] = '{0, 4, 5, 8, 6, 7, 3, 2};
    alu_of = tab[f3];
    if (f3 == 3'd0 && rtype && f7) alu_of = 1;
    if (f3 == 3'd5 && f7) alu_of = 15;
  endfunction

  function automatic int br_alu(input logic [2:0] f3);
    int tab[8] = '{1, 1, 0, 0, 5, 5, 8, 8};
    br_alu = tab[f3];
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'b000, 3'b101, 3'b111: taken = z;
      3'b001, 3'b100, 3'b110: taken = !z;
      default:                taken = 1'b0;
    endcase
  endfunction

  // Expected per-cycle control sequence for one instruction
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    exp_t wb = mk(7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, o == BR ? 2 : o == JL ? 3 : 0, 0));
    case (o)
      LW: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        exp_q.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      SW: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
        exp_q.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      RT: begin exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, alu_of(f3, f7, 1))); exp_q.push_back(wb); end
      IT: begin exp_q.push_back(mk(8, 0, 0, 0, 0, 0, 0, 2, 1, 0, alu_of(f3, f7, 0))); exp_q.push_back(wb); end
      JL: begin exp_q.push_back(mk(9, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0)); exp_q.push_back(wb); end
      BR: exp_q.push_back(mk(10, 0, 0, 0, 0, 0, 0, 2, 0, 0, br_alu(f3), 1));
      LU: begin exp_q.push_back(mk(11, 0, 0, 0, 0, 0, 0, 3, 1, 4, 0)); exp_q.push_back(wb); end
      JR: begin
        exp_q.push_back(mk(12, 1, 0, 0, 0, 0, 2, 2, 1, 0, 0));
        exp_q.push_back(mk(9, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        exp_q.push_back(wb);
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] got_vec();
    got_vec = {9'd0, state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUcontrol, illegal};
  endfunction

  // Called just after a falling edge; returns just after the next falling edge
  task automatic step(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zf);
    exp_t        e;
    logic [31:0] want;
    e = exp_q.pop_front();
    if (e.st == 4'd0) begin op = o; funct3 = f3; funct7b5 = f7; end
    Zero = zf < 0 ? 1'($urandom_range(0, 1)) : 1'(zf);
    #1;
    want = {9'd0, e.st, e.br ? taken(f3, Zero) : e.pcw, e.adr, e.memw, e.irw, e.regw, e.res, e.a, e.b,
            e.imm, e.alu, e.il};
    check($sformatf("op%b_f3%0d_f7%0d_st%0d", o, f3, f7, e.st), got_vec(), want);
    @(negedge clk);
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zf,
                     input int lim = 100);
    build(o, f3, f7);
    for (int i = 0; i < lim && exp_q.size() > 0; i++) step(o, f3, f7, zf);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check("reset", {23'd0, state_o, PCWrite, IRWrite, RegWrite, MemWrite, illegal}, 32'd0);
    end
    reset = 1'b0;
  endtask

  logic [6:0] ops[8] = '{LW, SW, RT, IT, JL, BR, LU, JR};

  initial begin
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    do_reset(2);
    run(RT, 3'd0, 1'b0, -1);
    run(RT, 3'd0, 1'b1, -1);
    run(RT, 3'd5, 1'b1, -1);
    run(IT, 3'd5, 1'b1, -1);
    run(IT, 3'd0, 1'b1, -1);
    run(BR, 3'd0, 1'b0, 1);
    run(BR, 3'd1, 1'b0, 1);
    run(BR, 3'd6, 1'b0, 0);
    run(BR, 3'd2, 1'b0, 1);
    run(LW, 3'd2, 1'b0, -1);
    run(SW, 3'd2, 1'b0, -1);
    run(JL, 3'd0, 1'b0, -1);
    run(LU, 3'd0, 1'b0, -1);
    run(JR, 3'd0, 1'b0, -1);
    // Abort a load in MEMWB: the register write must not fire in the reset cycle
    run(LW, 3'd2, 1'b0, -1, 4);
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("abort_memwb", {24'd0, state_o, PCWrite, IRWrite, RegWrite, MemWrite}, {24'd0, 4'd4, 4'b0000});
    do_reset(1);
    for (int n = 0; n < 300; n++)
      run(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);
    run(7'b0000000, 3'd0, 1'b0, -1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      step(7'b0000000, 3'd0, 1'b0, -1);
    end
    do_reset(1);
`endif
    run(RT, 3'd7, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
